// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave timer front end.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        LOAD    = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic valid;
        bcd_t digit;
    } key_dec_t;

    // Largest legal tens-of-seconds digit in an mm:ss entry.
    localparam bcd_t MAX_SEC_TENS = 4'd5;

    // Decode a one-hot digit key vector; valid is low for any other pattern.
    function automatic key_dec_t onehot10_to_bcd(input logic [9:0] key);
        key_dec_t r;
        r.valid = 1'b1;
        r.digit = 4'd0;
        case (key)
            10'b00_0000_0001: r.digit = 4'd0;
            10'b00_0000_0010: r.digit = 4'd1;
            10'b00_0000_0100: r.digit = 4'd2;
            10'b00_0000_1000: r.digit = 4'd3;
            10'b00_0001_0000: r.digit = 4'd4;
            10'b00_0010_0000: r.digit = 4'd5;
            10'b00_0100_0000: r.digit = 4'd6;
            10'b00_1000_0000: r.digit = 4'd7;
            10'b01_0000_0000: r.digit = 4'd8;
            10'b10_0000_0000: r.digit = 4'd9;
            default: begin
                r.valid = 1'b0;
                r.digit = 4'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Stability counter for the digit keys. Counts consecutive edges of an
// unchanged one-hot pattern while pressing, and consecutive all-zero edges
// while releasing. Pulses are combinational on the edge that completes a run.
module key_debounce
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] key,
    input  logic       key_valid,
    input  state_t     fsm_state,
    input  logic       flush,
    output logic       press_ok,
    output logic       release_ok
);

    localparam logic [7:0] DB = 8'(DEBOUNCE);

    logic [7:0] cnt_r;
    logic [9:0] last_r;
    logic [7:0] run_s;

    // Length of the current stable run including this edge.
    always_comb begin
        run_s      = 8'd0;
        press_ok   = 1'b0;
        release_ok = 1'b0;
        case (fsm_state)
            IDLE: begin
                if (key_valid) run_s = 8'd1;
                else           run_s = 8'd0;
            end
            PRESS: begin
                if (key_valid && (key == last_r)) run_s = cnt_r + 8'd1;
                else if (key_valid)               run_s = 8'd1;
                else                              run_s = 8'd0;
            end
            RELEASE: begin
                if (key == 10'd0) run_s = cnt_r + 8'd1;
                else              run_s = 8'd0;
            end
            default: run_s = 8'd0;
        endcase
        press_ok   = ((fsm_state == IDLE) || (fsm_state == PRESS)) && key_valid && (run_s == DB);
        release_ok = (fsm_state == RELEASE) && (key == 10'd0) && (run_s == DB);
    end

    // Run counter and previous key pattern; a completed run starts over at 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r  <= 8'd0;
            last_r <= 10'd0;
        end else begin
            last_r <= key;
            if (flush || press_ok || release_ok) cnt_r <= 8'd0;
            else                                 cnt_r <= run_s;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Microwave time entry: debounced digit keys shift into an mm:ss BCD
// register; an accepted start pulses loadn low for one cycle.
module keypad_entry
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] key,
    input  logic       start,
    input  logic       cancel,
    input  logic       running,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       loadn,
    output logic       err
);

    state_t   state_r, state_nxt_s;
    bcd_t     d0_r, d1_r, d2_r, d3_r;
    logic     start_d_r, loadn_r, err_r;
    key_dec_t dec_s;
    logic     start_rise_s, start_good_s;
    logic     shift_s, clear_s, err_s, flush_s;
    logic     press_ok_s, release_ok_s;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk        (clk),
        .clr        (clr),
        .key        (key),
        .key_valid  (dec_s.valid),
        .fsm_state  (state_r),
        .flush      (flush_s),
        .press_ok   (press_ok_s),
        .release_ok (release_ok_s)
    );

    // Next state and per-edge actions; priority cancel > running > start > key.
    always_comb begin
        dec_s        = onehot10_to_bcd(key);
        start_rise_s = start & ~start_d_r;
        start_good_s = (|{d3_r, d2_r, d1_r, d0_r}) && (d1_r <= MAX_SEC_TENS);
        state_nxt_s  = state_r;
        shift_s      = 1'b0;
        clear_s      = 1'b0;
        err_s        = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            LOAD: begin
                state_nxt_s = IDLE;
                clear_s     = 1'b1;
            end
            IDLE, PRESS, RELEASE: begin
                if (cancel) begin
                    clear_s     = 1'b1;
                    flush_s     = 1'b1;
                    state_nxt_s = running ? IDLE : RELEASE;
                end else if (running) begin
                    flush_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else if ((state_r == IDLE) && start_rise_s) begin
                    flush_s = 1'b1;
                    if (start_good_s) state_nxt_s = LOAD;
                    else              err_s       = 1'b1;
                end else if (press_ok_s) begin
                    shift_s     = 1'b1;
                    state_nxt_s = RELEASE;
                end else if (release_ok_s) begin
                    state_nxt_s = IDLE;
                end else if (state_r == RELEASE) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = dec_s.valid ? PRESS : IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, digit shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= IDLE;
            d0_r      <= 4'd0;
            d1_r      <= 4'd0;
            d2_r      <= 4'd0;
            d3_r      <= 4'd0;
            start_d_r <= 1'b0;
            loadn_r   <= 1'b1;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            start_d_r <= start;
            loadn_r   <= (state_nxt_s != LOAD);
            err_r     <= err_s;
            if (clear_s) begin
                d0_r <= 4'd0;
                d1_r <= 4'd0;
                d2_r <= 4'd0;
                d3_r <= 4'd0;
            end else if (shift_s) begin
                d3_r <= d2_r;
                d2_r <= d1_r;
                d1_r <= d0_r;
                d0_r <= dec_s.digit;
            end else begin
                d0_r <= d0_r;
                d1_r <= d1_r;
                d2_r <= d2_r;
                d3_r <= d3_r;
            end
        end
    end

    assign sec_ones = d0_r;
    assign sec_tens = d1_r;
    assign min_ones = d2_r;
    assign min_tens = d3_r;
    assign loadn    = loadn_r;
    assign err      = err_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural model of the entry value.
module tb_keypad_entry;

    localparam int D = 4;

    logic       clk;
    logic       clr, start, cancel, running;
    logic [9:0] key;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       loadn, err;

    int total = 0;
    int bad   = 0;

    // Model: entry held as a decimal number mmss, phase 0 idle/1 press/2 release/3 load.
    int         m_e     = 0;
    int         m_phase = 0;
    int         m_run   = 0;
    logic [9:0] m_held  = 10'd0;
    bit         m_prev_start = 1'b0;
    bit         m_loadn = 1'b1;
    bit         m_err   = 1'b0;

    keypad_entry #(.DEBOUNCE(D)) dut (
        .clk      (clk),
        .clr      (clr),
        .key      (key),
        .start    (start),
        .cancel   (cancel),
        .running  (running),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .loadn    (loadn),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_digits();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step();
        bit rise;
        bit oh;
        int d;
        rise = start && !m_prev_start;
        oh   = ($countones(key) == 1);
        d    = 0;
        for (int i = 0; i < 10; i++) if (key[i]) d = i;
        m_loadn = 1'b1;
        m_err   = 1'b0;
        if (clr) begin
            m_e = 0; m_phase = 0; m_run = 0; m_prev_start = 1'b0;
        end else begin
            m_prev_start = start;
            if (m_phase == 3) begin
                m_e = 0; m_phase = 0;
            end else if (cancel) begin
                m_e = 0; m_phase = running ? 0 : 2; m_run = 0;
            end else if (running) begin
                m_phase = 0; m_run = 0;
            end else if (m_phase == 0 && rise) begin
                if (m_e != 0 && (m_e / 10) % 10 <= 5) begin
                    m_phase = 3; m_loadn = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                case (m_phase)
                    0: if (oh) begin m_phase = 1; m_held = key; m_run = 1; end
                    1: begin
                        if (!oh) m_phase = 0;
                        else if (key != m_held) begin m_held = key; m_run = 1; end
                        else m_run++;
                    end
                    2: m_run = (key == 10'd0) ? m_run + 1 : 0;
                    default: m_phase = 0;
                endcase
                if (m_phase == 1 && m_run >= D) begin
                    m_e = (m_e * 10 + d) % 10000;
                    m_phase = 2; m_run = 0;
                end else if (m_phase == 2 && m_run >= D) begin
                    m_phase = 0; m_run = 0;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic press(input int d);
        logic [9:0] one;
        one = 10'd1;
        key = one << d;
        cyc(D + 1);
        key = 10'd0;
        cyc(D + 1);
    endtask

    // Compare all outputs against the model after every edge.
    always @(negedge clk) begin
        check("sec_ones", int'(sec_ones), m_e % 10);
        check("sec_tens", int'(sec_tens), (m_e / 10) % 10);
        check("min_ones", int'(min_ones), (m_e / 100) % 10);
        check("min_tens", int'(min_tens), (m_e / 1000) % 10);
        check("loadn", int'(loadn), int'(m_loadn));
        check("err", int'(err), int'(m_err));
    end

    initial begin
        int         r;
        logic [9:0] one;
        clr = 1'b1; start = 1'b0; cancel = 1'b0; running = 1'b0; key = 10'd0;
        cyc(2);
        check("reset_digits", dut_digits(), 32'h0000);
        check("reset_loadn", int'(loadn), 1);
        check("reset_err", int'(err), 0);
        clr = 1'b0;
        cyc(1);

        // 01:30 then start
        press(1); press(3); press(0);
        check("entry_0130", dut_digits(), 32'h0130);
        check("model_0130", m_e, 130);
        start = 1'b1; cyc(1);
        check("load_low", int'(loadn), 0);
        check("load_data", dut_digits(), 32'h0130);
        start = 1'b0; cyc(1);
        check("load_done", int'(loadn), 1);
        check("cleared_after_load", dut_digits(), 32'h0000);

        // glitch then long hold
        key = 10'h004; cyc(D - 1);
        key = 10'd0;   cyc(2);
        check("glitch_ignored", dut_digits(), 32'h0000);
        key = 10'h004; cyc(20);
        key = 10'd0;   cyc(D + 1);
        check("single_accept", dut_digits(), 32'h0002);

        // five digits
        cancel = 1'b1; cyc(1); cancel = 1'b0; cyc(D + 1);
        press(1); press(2); press(3); press(4); press(5);
        check("entry_2345", dut_digits(), 32'h2345);
        start = 1'b1; cyc(1);
        check("load_2345", int'(loadn), 0);
        start = 1'b0; cyc(1);

        // 0:75 rejected
        press(7); press(5);
        start = 1'b1; cyc(1);
        check("err_075", int'(err), 1);
        check("noload_075", int'(loadn), 1);
        check("kept_075", dut_digits(), 32'h0075);
        start = 1'b0; cyc(1);

        // zero entry rejected
        cancel = 1'b1; cyc(1); cancel = 1'b0; cyc(D + 1);
        start = 1'b1; cyc(1);
        check("err_zero", int'(err), 1);

        // start held across entry
        press(1); press(2);
        check("held_start_noload", dut_digits(), 32'h0012);
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        check("load_after_rise", int'(loadn), 0);
        start = 1'b0; cyc(1);

        // cancel beats start
        press(3); press(0);
        cancel = 1'b1; start = 1'b1; cyc(1);
        check("cancel_digits", dut_digits(), 32'h0000);
        check("cancel_noload", int'(loadn), 1);
        check("cancel_noerr", int'(err), 0);
        cancel = 1'b0; start = 1'b0; cyc(D + 1);

        // two keys at once
        key = 10'h005; cyc(10); key = 10'd0; cyc(2);
        check("twokey_ignored", dut_digits(), 32'h0000);

        // running blocks keys and start, cancel still clears
        press(9);
        running = 1'b1;
        press(1);
        start = 1'b1; cyc(1);
        check("running_noerr", int'(err), 0);
        start = 1'b0; cyc(1);
        check("running_keep", dut_digits(), 32'h0009);
        cancel = 1'b1; cyc(1);
        check("running_cancel", dut_digits(), 32'h0000);
        cancel = 1'b0; running = 1'b0; cyc(D + 1);

        // clr during PRESS
        press(4);
        one = 10'd1; key = one << 5; cyc(2);
        clr = 1'b1; cyc(1);
        check("clr_digits", dut_digits(), 32'h0000);
        clr = 1'b0; key = 10'd0; cyc(D + 1);

        // random phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 19));
                if (r < 9)       key = 10'd0;
                else if (r < 17) begin one = 10'd1; key = one << $urandom_range(0, 9); end
                else             key = 10'($urandom);
            end
            if ($urandom_range(0, 9) == 0) start = ~start;
            cancel = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 149) == 0) running = ~running;
            clr = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
